oht2bin_pipe: RTL and testbench

Pipelined, stream-handshaked one-hot to binary index encoder, built as a SPLIT-ary reduction tree. It is the consumer-side counterpart of the priority-to-one-hot tree: it turns one-hot grant and select vectors back into a binary index for muxing, memory addressing or logging. It also flags all-zero and multi-hot inputs, with a defined priority resolution for multi-hot. Register slices between tree levels keep long WIDTH vectors at full clock rate.

---
 rtl/oht2bin_pipe.sv | 157 +++++++++++++++
 tb/tb_oht2bin_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oht2bin_pipe.sv
// oht2bin_pipe: pipelined one-hot to binary index encoder built as a SPLIT-ary
// reduction tree with valid/ready stream handshakes on both sides.
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready input handshake; s_oht is the (expected) one-hot vector
//   m_valid/m_ready output handshake
//   m_bin           index of the DIRECTION-priority set bit (0 when none set)
//   m_zero          input had no bit set
//   m_err           input had more than one bit set
module oht2bin_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SPLIT      = 2,
  parameter string       DIRECTION  = "LSB",
  parameter int unsigned REG_LEVELS = 1,
  localparam int unsigned BW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_oht,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BW-1:0]    m_bin,
  output logic             m_zero,
  output logic             m_err
);

  function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < e; i++) p = p * b;
    return p;
  endfunction

  function automatic int unsigned calc_levels(input int unsigned w, input int unsigned s);
    int unsigned p;
    int unsigned n;
    p = 1;
    n = 0;
    while (p < w) begin
      p = p * s;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int unsigned LEVELS    = calc_levels(WIDTH, SPLIT);
  localparam bit          MSB_FIRST = (DIRECTION == "MSB");

  // One generate iteration per tree level; level 0 consumes raw input bits,
  // treated as child triples {any=bit, err=0, idx=0}.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned LV     = l;
    localparam int unsigned WT     = ipow(SPLIT, LV);
    localparam int unsigned NIN    = WIDTH / WT;
    localparam int unsigned NOUT   = NIN / SPLIT;
    localparam bit          IS_REG = (((LV + 1) % REG_LEVELS) == 0) || (LV == LEVELS - 1);

    logic             in_vld;
    logic             in_rdy;
    logic             out_vld;
    logic             out_rdy;
    logic [NIN-1:0]   c_any;
    logic [NIN-1:0]   c_err;
    logic [BW-1:0]    c_idx [NIN];
    logic [NOUT-1:0]  n_any;
    logic [NOUT-1:0]  n_err;
    logic [BW-1:0]    n_idx [NOUT];
    logic [NOUT-1:0]  o_any;
    logic [NOUT-1:0]  o_err;
    logic [BW-1:0]    o_idx [NOUT];

    // Child triples: raw bits at the leaves, previous level otherwise
    if (l == 0) begin : g_src
      assign in_vld = s_valid;
      assign c_any  = s_oht;
      assign c_err  = '0;
      always_comb begin
        for (int i = 0; i < NIN; i++) c_idx[i] = '0;
      end
    end else begin : g_src
      assign in_vld = g_lvl[l-1].out_vld;
      assign c_any  = g_lvl[l-1].o_any;
      assign c_err  = g_lvl[l-1].o_err;
      assign c_idx  = g_lvl[l-1].o_idx;
    end

    // Ready comes from the next level, or from the sink at the root
    if (l == LEVELS - 1) begin : g_rdy
      assign out_rdy = m_ready;
    end else begin : g_rdy
      assign out_rdy = g_lvl[l+1].in_rdy;
    end

    // Node combine; idx is built arithmetically (sel * SPLIT^l + child idx)
    // so that non-power-of-two SPLIT still yields a plain binary index.
    always_comb begin
      n_any = '0;
      n_err = '0;
      for (int n = 0; n < NOUT; n++) n_idx[n] = '0;
      for (int n = 0; n < NOUT; n++) begin
        for (int j = 0; j < SPLIT; j++) begin
          if (c_err[n*SPLIT + j]) n_err[n] = 1'b1;
          if (c_any[n*SPLIT + j]) begin
            if (n_any[n]) n_err[n] = 1'b1;
            if (!n_any[n] || MSB_FIRST) n_idx[n] = BW'(j * WT) + c_idx[n*SPLIT + j];
            n_any[n] = 1'b1;
          end
        end
      end
    end

    if (IS_REG) begin : g_stage
      logic            vq;
      logic [NOUT-1:0] r_any;
      logic [NOUT-1:0] r_err;
      logic [BW-1:0]   r_idx [NOUT];

      // Stage register: loads when empty or when downstream takes its item
      always_ff @(posedge clk) begin
        if (rst) begin
          vq    <= 1'b0;
          r_any <= '0;
          r_err <= '0;
          for (int i = 0; i < NOUT; i++) r_idx[i] <= '0;
        end else if (in_rdy) begin
          vq <= in_vld;
          if (in_vld) begin
            r_any <= n_any;
            r_err <= n_err;
            r_idx <= n_idx;
          end
        end
      end

      assign in_rdy  = !vq || out_rdy;
      assign out_vld = vq;
      assign o_any   = r_any;
      assign o_err   = r_err;
      assign o_idx   = r_idx;
    end else begin : g_stage
      assign in_rdy  = out_rdy;
      assign out_vld = in_vld;
      assign o_any   = n_any;
      assign o_err   = n_err;
      assign o_idx   = n_idx;
    end
  end

  assign s_ready = g_lvl[0].in_rdy && !rst;
  assign m_valid = g_lvl[LEVELS-1].out_vld;
  assign m_bin   = g_lvl[LEVELS-1].o_idx[0];
  // Gated by valid so the cleared pipeline reports m_zero=0
  assign m_zero  = m_valid && !g_lvl[LEVELS-1].o_any[0];
  assign m_err   = g_lvl[LEVELS-1].o_err[0];

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Scoreboard bench for oht2bin_pipe: four instances (32/2 LSB and MSB with
// two levels per stage, 27/3, 4/4); expected responses are queued on accept
// and popped by per-instance monitors whenever an output transfer occurs.
module tb_oht2bin_pipe;

  typedef struct packed {
    logic [6:0]  e;     // {err, zero, bin[4:0]}
    logic        chk;   // check exact latency for this item
    logic [31:0] acc;   // edge number at which it was accepted
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready, m_zero, m_err;
  logic [31:0] s_oht;
  logic [4:0]  m_bin;

  logic        b_s_valid, b_s_ready, b_m_valid, b_m_zero, b_m_err;
  logic [4:0]  b_m_bin;

  logic        t_s_valid, t_s_ready, t_m_valid, t_m_zero, t_m_err;
  logic [26:0] t_s_oht;
  logic [4:0]  t_m_bin;

  logic        f_s_valid, f_s_ready, f_m_valid, f_m_zero, f_m_err;
  logic [3:0]  f_s_oht;
  logic [1:0]  f_m_bin;

  assign b_s_valid = s_valid && s_ready;

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2), .DIRECTION("LSB"), .REG_LEVELS(2)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_oht(s_oht),
    .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin), .m_zero(m_zero), .m_err(m_err));

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2), .DIRECTION("MSB"), .REG_LEVELS(2)) u_msb (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_oht(s_oht),
    .m_valid(b_m_valid), .m_ready(1'b1), .m_bin(b_m_bin), .m_zero(b_m_zero), .m_err(b_m_err));

  oht2bin_pipe #(.WIDTH(27), .SPLIT(3), .DIRECTION("LSB"), .REG_LEVELS(1)) u_w27 (
    .clk(clk), .rst(rst), .s_valid(t_s_valid), .s_ready(t_s_ready), .s_oht(t_s_oht),
    .m_valid(t_m_valid), .m_ready(1'b1), .m_bin(t_m_bin), .m_zero(t_m_zero), .m_err(t_m_err));

  oht2bin_pipe #(.WIDTH(4), .SPLIT(4), .DIRECTION("LSB"), .REG_LEVELS(1)) u_w4 (
    .clk(clk), .rst(rst), .s_valid(f_s_valid), .s_ready(f_s_ready), .s_oht(f_s_oht),
    .m_valid(f_m_valid), .m_ready(1'b1), .m_bin(f_m_bin), .m_zero(f_m_zero), .m_err(f_m_err));

  exp_t q_a[$], q_b[$], q_t[$], q_f[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic [6:0] exp_lsb, exp_msb, exp_t27, exp_f4;
  logic       cur_chk;
  logic       hold;
  logic [6:0] held;
  int         bp_bin [4] = '{5, 9, 13, 20};
  int         nacc, k, sent, cycles;
  logic       acc;
  logic [31:0] v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output with empty scoreboard (cycle %0d)", name, cyc);
  endtask

  task automatic cmp_item(input string name, input exp_t x, input logic [6:0] act, input int lat);
    check(name, 32'(act), 32'(x.e));
    if (x.chk) check({name, "_latency"}, 32'(cyc), x.acc + 32'(lat) - 32'd1);
  endtask

  function automatic logic [6:0] e(input bit err, input bit zero, input int bin);
    return {err, zero, 5'(bin)};
  endfunction

  // Flat reference: scan all bits, count them, keep first or last set index
  function automatic logic [6:0] model(input logic [31:0] x, input bit msb);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) begin
        if (cnt == 0 || msb) idx = i;
        cnt++;
      end
    end
    return {cnt > 1, cnt == 0, 5'(idx)};
  endfunction

  // Scoreboard push on every input transfer
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete(); q_b.delete(); q_t.delete(); q_f.delete();
    end else begin
      if (s_valid && s_ready) begin
        q_a.push_back('{exp_lsb, cur_chk, 32'(cyc + 1)});
        q_b.push_back('{exp_msb, cur_chk, 32'(cyc + 1)});
      end
      if (t_s_valid && t_s_ready) q_t.push_back('{exp_t27, 1'b1, 32'(cyc + 1)});
      if (f_s_valid && f_s_ready) q_f.push_back('{exp_f4, 1'b1, 32'(cyc + 1)});
    end
  end

  // Main monitor: pop on output transfer, check hold stability under stall
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'({m_err, m_zero, m_bin}), 32'(held));
      end
      if (m_valid && m_ready) begin
        if (q_a.size() == 0) unexpected("lsb_out");
        else cmp_item("lsb_out", q_a.pop_front(), {m_err, m_zero, m_bin}, 3);
      end
      hold = m_valid && !m_ready;
      held = {m_err, m_zero, m_bin};
    end
  end

  always @(negedge clk) begin
    if (!rst && b_m_valid) begin
      if (q_b.size() == 0) unexpected("msb_out");
      else cmp_item("msb_out", q_b.pop_front(), {b_m_err, b_m_zero, b_m_bin}, 3);
    end
    if (!rst && t_m_valid) begin
      if (q_t.size() == 0) unexpected("w27_out");
      else cmp_item("w27_out", q_t.pop_front(), {t_m_err, t_m_zero, t_m_bin}, 3);
    end
    if (!rst && f_m_valid) begin
      if (q_f.size() == 0) unexpected("w4_out");
      else cmp_item("w4_out", q_f.pop_front(), {f_m_err, f_m_zero, 3'b000, f_m_bin}, 1);
    end
  end

  // Offer one item on the main stream and wait (bounded) for acceptance
  task automatic drive(input logic [31:0] x, input logic [6:0] el, input logic [6:0] em,
                       input logic chk);
    s_oht   = x;
    exp_lsb = el;
    exp_msb = em;
    cur_chk = chk;
    s_valid = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (s_ready) break;
      if (c == 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL drive_timeout: s_ready=%0b, required 1 within 40 cycles", s_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_bp(input int i);
    s_oht   = 32'd1 << bp_bin[i];
    exp_lsb = e(0, 0, bp_bin[i]);
    exp_msb = e(0, 0, bp_bin[i]);
    cur_chk = 1'b0;
  endtask

  task automatic drive_small(input logic [26:0] tv, input logic [6:0] te,
                             input logic [3:0] fv, input logic [6:0] fe);
    t_s_oht = tv; exp_t27 = te; t_s_valid = 1'b1;
    f_s_oht = fv; exp_f4  = fe; f_s_valid = 1'b1;
    @(negedge clk);
    check("w27_s_ready", 32'(t_s_ready), 32'd1);
    check("w4_s_ready", 32'(f_s_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_oht = '0; m_ready = 1'b0; cur_chk = 1'b0;
    exp_lsb = '0; exp_msb = '0; exp_t27 = '0; exp_f4 = '0;
    t_s_valid = 1'b0; t_s_oht = '0; f_s_valid = 1'b0; f_s_oht = '0;
    hold = 1'b0; held = '0;

    // Reset values
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    check("post_rst_m_bin", 32'(m_bin), 32'd0);
    check("post_rst_m_zero", 32'(m_zero), 32'd0);
    check("post_rst_m_err", 32'(m_err), 32'd0);
    check("post_rst_w4_ready", 32'(f_s_ready), 32'd1);
    @(posedge clk); #1;

    // Walking one, back to back, exact latency
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) drive(32'd1 << i, e(0, 0, i), e(0, 0, i), 1'b1);
    // Zero and multi-hot cases
    drive(32'h0000_0000, e(0, 1, 0), e(0, 1, 0),  1'b1);
    drive(32'h8000_0011, e(1, 0, 0), e(1, 0, 31), 1'b1);
    drive(32'h0001_0100, e(1, 0, 8), e(1, 0, 16), 1'b1);
    drive(32'h0000_0006, e(1, 0, 1), e(1, 0, 2),  1'b1);
    drive(32'hFFFF_FFFF, e(1, 0, 0), e(1, 0, 31), 1'b1);
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: three accepts fill the pipe, then release
    m_ready = 1'b0;
    nacc = 0;
    k = 0;
    set_bp(0);
    s_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (acc) nacc++;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 4) set_bp(k);
      end
    end
    @(negedge clk);
    check("bp_accepts", 32'(nacc), 32'd3);
    check("bp_s_ready", 32'(s_ready), 32'd0);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_head_bin", 32'(m_bin), 32'd5);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_flow_valid", 32'(m_valid), 32'd1);
      if (c == 0) check("bp_release_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;

    // Reset with three items in flight
    m_ready = 1'b0;
    drive(32'd1 << 3, e(0, 0, 3), e(0, 0, 3), 1'b0);
    drive(32'd1 << 4, e(0, 0, 4), e(0, 0, 4), 1'b0);
    drive(32'd1 << 6, e(0, 0, 6), e(0, 0, 6), 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    check("mid_rst_m_bin", 32'(m_bin), 32'd0);
    check("mid_rst_m_zero", 32'(m_zero), 32'd0);
    check("mid_rst_m_err", 32'(m_err), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // Random valid/ready toggling against the flat model
    sent = 0;
    cycles = 0;
    s_valid = 1'b0;
    cur_chk = 1'b0;
    while (sent < 10000 && cycles < 60000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) sent++;
      if (!s_valid || acc) begin
        case ($urandom_range(0, 3))
          0, 1:    v = 32'd1 << $urandom_range(0, 31);
          2:       v = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          default: v = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        endcase
        s_oht   = v;
        exp_lsb = model(v, 1'b0);
        exp_msb = model(v, 1'b1);
        s_valid = ($urandom_range(0, 1) == 1);
      end
      m_ready = ($urandom_range(0, 1) == 1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("rand_sent", 32'(sent), 32'd10000);

    // Ternary tree and single-leaf configurations
    drive_small(27'd1 << 26,   e(0, 0, 26), 4'b0100, e(0, 0, 2));
    drive_small(27'h000_0201,  e(1, 0, 0),  4'b1010, e(1, 0, 1));
    drive_small(27'd1 << 13,   e(0, 0, 13), 4'b0000, e(0, 1, 0));
    drive_small(27'h000_0000,  e(0, 1, 0),  4'b1000, e(0, 0, 3));
    drive_small(27'h400_0100,  e(1, 0, 8),  4'b0001, e(0, 0, 0));
    t_s_valid = 1'b0;
    f_s_valid = 1'b0;

    // Drain and confirm nothing was lost
    for (int c = 0; c < 50; c++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_t.size() == 0 && q_f.size() == 0) break;
      @(negedge clk);
    end
    check("drain_lsb", 32'(q_a.size()), 32'd0);
    check("drain_msb", 32'(q_b.size()), 32'd0);
    check("drain_w27", 32'(q_t.size()), 32'd0);
    check("drain_w4", 32'(q_f.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
